// File: rtl/icb_arb_2m1s_pkg.sv
// Shared bus widths and FSM encoding for the two-master ICB arbiter.
package icb_arb_2m1s_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_MASK_W = MEM_DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RSP  = 2'd2,
    ST_ERR  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/icb_arb_2m1s.sv
// Two-master, one-slave ICB arbiter: round-robin, one transaction in flight,
// with a slave response timeout that answers the owner with an error.
module icb_arb_2m1s
  import icb_arb_2m1s_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  m0_icb_cmd_valid,
  output logic                  m0_icb_cmd_ready,
  input  logic [MEM_ADDR_W-1:0] m0_icb_cmd_addr,
  input  logic                  m0_icb_cmd_read,
  input  logic [MEM_DATA_W-1:0] m0_icb_cmd_wdata,
  input  logic [MEM_MASK_W-1:0] m0_icb_cmd_wmask,
  output logic                  m0_icb_rsp_valid,
  input  logic                  m0_icb_rsp_ready,
  output logic                  m0_icb_rsp_err,
  output logic [MEM_DATA_W-1:0] m0_icb_rsp_rdata,

  input  logic                  m1_icb_cmd_valid,
  output logic                  m1_icb_cmd_ready,
  input  logic [MEM_ADDR_W-1:0] m1_icb_cmd_addr,
  input  logic                  m1_icb_cmd_read,
  input  logic [MEM_DATA_W-1:0] m1_icb_cmd_wdata,
  input  logic [MEM_MASK_W-1:0] m1_icb_cmd_wmask,
  output logic                  m1_icb_rsp_valid,
  input  logic                  m1_icb_rsp_ready,
  output logic                  m1_icb_rsp_err,
  output logic [MEM_DATA_W-1:0] m1_icb_rsp_rdata,

  output logic                  s_icb_cmd_valid,
  input  logic                  s_icb_cmd_ready,
  output logic [MEM_ADDR_W-1:0] s_icb_cmd_addr,
  output logic                  s_icb_cmd_read,
  output logic [MEM_DATA_W-1:0] s_icb_cmd_wdata,
  output logic [MEM_MASK_W-1:0] s_icb_cmd_wmask,
  input  logic                  s_icb_rsp_valid,
  output logic                  s_icb_rsp_ready,
  input  logic                  s_icb_rsp_err,
  input  logic [MEM_DATA_W-1:0] s_icb_rsp_rdata,

  output logic [1:0]            grant_o,
  output logic                  tout_pulse_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_e      state, state_nxt;
  logic            owner, owner_nxt;   // 0 = m0, 1 = m1
  logic            last, last_nxt;     // master that completed most recently
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic            tout_q;

  // Owner-side views of the selected master.
  logic                  sel_cmd_valid;
  logic [MEM_ADDR_W-1:0] sel_cmd_addr;
  logic                  sel_cmd_read;
  logic [MEM_DATA_W-1:0] sel_cmd_wdata;
  logic [MEM_MASK_W-1:0] sel_cmd_wmask;
  logic                  sel_rsp_ready;

  logic                  own_cmd_ready;
  logic                  own_rsp_valid;
  logic                  own_rsp_err;
  logic [MEM_DATA_W-1:0] own_rsp_rdata;

  assign sel_cmd_valid = owner ? m1_icb_cmd_valid : m0_icb_cmd_valid;
  assign sel_cmd_addr  = owner ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
  assign sel_cmd_read  = owner ? m1_icb_cmd_read  : m0_icb_cmd_read;
  assign sel_cmd_wdata = owner ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
  assign sel_cmd_wmask = owner ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;
  assign sel_rsp_ready = owner ? m1_icb_rsp_ready : m0_icb_rsp_ready;
  assign cnt_inc       = cnt + 1'b1;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt       = state;
    owner_nxt       = owner;
    last_nxt        = last;
    cnt_nxt         = cnt;
    s_icb_cmd_valid = 1'b0;
    s_icb_cmd_addr  = '0;
    s_icb_cmd_read  = 1'b0;
    s_icb_cmd_wdata = '0;
    s_icb_cmd_wmask = '0;
    s_icb_rsp_ready = 1'b1;
    own_cmd_ready   = 1'b0;
    own_rsp_valid   = 1'b0;
    own_rsp_err     = 1'b0;
    own_rsp_rdata   = '0;

    unique case (state)
      ST_IDLE: begin
        if (m0_icb_cmd_valid || m1_icb_cmd_valid) begin
          if (m0_icb_cmd_valid && m1_icb_cmd_valid) owner_nxt = ~last;
          else                                      owner_nxt = m1_icb_cmd_valid;
          state_nxt = ST_CMD;
        end
      end
      ST_CMD: begin
        s_icb_cmd_valid = sel_cmd_valid;
        s_icb_cmd_addr  = sel_cmd_addr;
        s_icb_cmd_read  = sel_cmd_read;
        s_icb_cmd_wdata = sel_cmd_wdata;
        s_icb_cmd_wmask = sel_cmd_wmask;
        own_cmd_ready   = s_icb_cmd_ready;
        if (sel_cmd_valid && s_icb_cmd_ready) begin
          state_nxt = ST_RSP;
          cnt_nxt   = '0;
        end
      end
      ST_RSP: begin
        own_rsp_valid   = s_icb_rsp_valid;
        own_rsp_err     = s_icb_rsp_err;
        own_rsp_rdata   = s_icb_rsp_rdata;
        s_icb_rsp_ready = sel_rsp_ready;
        if (s_icb_rsp_valid) begin
          if (sel_rsp_ready) begin
            state_nxt = ST_IDLE;
            last_nxt  = owner;
          end
        end else if (cnt_inc == CNT_LAST) begin
          state_nxt = ST_ERR;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ST_ERR: begin
        own_rsp_valid = 1'b1;
        own_rsp_err   = 1'b1;
        if (sel_rsp_ready) begin
          state_nxt = ST_IDLE;
          last_nxt  = owner;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      owner  <= 1'b0;
      last   <= 1'b1;
      cnt    <= '0;
      tout_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      last   <= last_nxt;
      cnt    <= cnt_nxt;
      tout_q <= (state == ST_RSP) && (state_nxt == ST_ERR);
    end
  end

  assign m0_icb_cmd_ready = !owner && own_cmd_ready;
  assign m0_icb_rsp_valid = !owner && own_rsp_valid;
  assign m0_icb_rsp_err   = !owner && own_rsp_err;
  assign m0_icb_rsp_rdata = owner ? '0 : own_rsp_rdata;
  assign m1_icb_cmd_ready = owner && own_cmd_ready;
  assign m1_icb_rsp_valid = owner && own_rsp_valid;
  assign m1_icb_rsp_err   = owner && own_rsp_err;
  assign m1_icb_rsp_rdata = owner ? own_rsp_rdata : '0;

  assign grant_o      = (state == ST_IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
  assign tout_pulse_o = tout_q;

endmodule
